// File: rtl/prog_loader_if.sv
// Byte-stream input and memory-write port of the program loader, bundled so the
// loader and its environment share one set of handshake and bus wires.
interface prog_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [31:0] Addr;
  logic [31:0] W_data;
  logic        W;
  logic        R;
  logic        ld_active;
  logic        cpu_reset;
  logic        done;
  logic        err;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, Addr, W_data, W, R, ld_active, cpu_reset, done, err
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, Addr, W_data, W, R, ld_active, cpu_reset, done, err
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: takes a little-endian word count plus that many little-endian
// 32-bit words from a byte stream and writes them to consecutive memory words.
module prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd4096,
  parameter int          MAX_WORDS = 1024
) (
  input logic             CLK,
  input logic             RESET,
  prog_loader_if.master   bus
);

  typedef enum logic [2:0] {
    HDR0  = 3'd0,
    HDR1  = 3'd1,
    WBYTE = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [15:0] n_q, n_d;
  logic [10:0] word_idx_q, word_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] asm_q, asm_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        w_q, w_d;
  logic        rdy_s;
  logic [15:0] n_new_s;
  logic [15:0] next_count_s;

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= HDR0;
      n_q        <= 16'd0;
      word_idx_q <= 11'd0;
      byte_idx_q <= 2'd0;
      asm_q      <= 24'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      w_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      w_q        <= w_d;
    end
  end

  // Next-state and datapath logic. Addr/W_data/W are loaded on the edge that
  // accepts a word's last byte, so they are already stable throughout WRITE.
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    word_idx_d   = word_idx_q;
    byte_idx_d   = byte_idx_q;
    asm_d        = asm_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    w_d          = 1'b0;
    rdy_s        = 1'b0;
    n_new_s      = {bus.byte_data, n_q[7:0]};
    next_count_s = {5'd0, word_idx_q} + 16'd1;

    case (state_q)
      HDR0: begin
        rdy_s = 1'b1;
        if (bus.byte_valid) begin
          n_d     = {n_q[15:8], bus.byte_data};
          state_d = HDR1;
        end else begin
          state_d = HDR0;
        end
      end
      HDR1: begin
        rdy_s = 1'b1;
        if (bus.byte_valid) begin
          n_d        = n_new_s;
          word_idx_d = 11'd0;
          byte_idx_d = 2'd0;
          if (n_new_s == 16'd0) begin
            state_d = DONE;
          end else if (n_new_s > MAX_N) begin
            state_d = ERR;
          end else begin
            state_d = WBYTE;
          end
        end else begin
          state_d = HDR1;
        end
      end
      WBYTE: begin
        rdy_s = 1'b1;
        if (bus.byte_valid) begin
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: asm_d[7:0]   = bus.byte_data;
            2'd1: asm_d[15:8]  = bus.byte_data;
            2'd2: asm_d[23:16] = bus.byte_data;
            2'd3: begin
              w_d     = 1'b1;
              addr_d  = BASE_ADDR + {19'd0, word_idx_q, 2'b00};
              wdata_d = {bus.byte_data, asm_q};
              state_d = WRITE;
            end
            default: state_d = HDR0;
          endcase
        end else begin
          state_d = WBYTE;
        end
      end
      WRITE: begin
        word_idx_d = word_idx_q + 11'd1;
        if (next_count_s == n_q) begin
          state_d = DONE;
        end else begin
          state_d = WBYTE;
        end
      end
      DONE:    state_d = DONE;
      ERR:     state_d = ERR;
      default: state_d = HDR0;
    endcase
  end

  assign bus.byte_ready = rdy_s & ~RESET;
  assign bus.Addr       = addr_q;
  assign bus.W_data     = wdata_q;
  assign bus.W          = w_q;
  assign bus.R          = 1'b0;
  assign bus.ld_active  = (state_q != DONE);
  assign bus.cpu_reset  = (state_q != DONE);
  assign bus.done       = (state_q == DONE);
  assign bus.err        = (state_q == ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: expected memory writes are queued as
// stimulus is driven and matched against every observed W pulse.
module tb_prog_loader;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic clk;
  logic rst;
  prog_loader_if dif();

  int   errors  = 0;
  int   checks  = 0;
  int   w_count = 0;
  logic [31:0] last_addr = 32'd0;
  wr_t  exp_q[$];
  wr_t  exp_e;

  prog_loader #(.BASE_ADDR(32'd4096), .MAX_WORDS(1024)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every W pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (dif.W === 1'b1) begin
      w_count++;
      last_addr = dif.Addr;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: Addr=%h W_data=%h, required no write", dif.Addr, dif.W_data);
      end else begin
        exp_e = exp_q.pop_front();
        if (dif.Addr !== exp_e.a || dif.W_data !== exp_e.d) begin
          errors++;
          $display("FAIL write_check: Addr=%h W_data=%h, required Addr=%h W_data=%h",
                   dif.Addr, dif.W_data, exp_e.a, exp_e.d);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    dif.byte_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    waited = 0;
    @(negedge clk);
    dif.byte_valid = 1'b1;
    dif.byte_data  = b;
    while (dif.byte_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (dif.byte_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL byte_accept: byte_ready=%b after %0d cycles, required 1", dif.byte_ready, waited);
    end else begin
      @(posedge clk);
      #1;
      if (gap > 0) begin
        dif.byte_valid = 1'b0;
        repeat (gap) @(posedge clk);
      end
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int idx, input bit gapped);
    wr_t e;
    e.a = 32'd4096 + 32'(idx) * 32'd4;
    e.d = w;
    exp_q.push_back(e);
    for (int b = 0; b < 4; b++) begin
      send_byte(w[8*b +: 8], gapped ? int'($urandom_range(0, 2)) : 0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dif.byte_valid = 1'b0;
    dif.byte_data  = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if ({dif.byte_ready, dif.W, dif.R, dif.ld_active, dif.cpu_reset, dif.done, dif.err} !== 7'b0001100) begin
      errors++;
      $display("FAIL reset_ctrl: rdy,W,R,ld,cpu_rst,done,err=%b, required 0001100",
               {dif.byte_ready, dif.W, dif.R, dif.ld_active, dif.cpu_reset, dif.done, dif.err});
    end
    checks++;
    if (dif.Addr !== 32'd0 || dif.W_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_bus: Addr=%h W_data=%h, required 0 0", dif.Addr, dif.W_data);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (dif.byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: byte_ready=%b, required 1", dif.byte_ready);
    end
  endtask

  task automatic test_two_words();
    int wc0;
    do_reset();
    wc0 = w_count;
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_word(32'h0001_0820, 0, 1'b0);
    send_word(32'h0000_1103, 1, 1'b0);
    checks++;
    if (dif.W !== 1'b1 || dif.done !== 1'b0) begin
      errors++;
      $display("FAIL last_write_latency: W=%b done=%b, required W=1 done=0", dif.W, dif.done);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({dif.done, dif.cpu_reset, dif.ld_active, dif.W} !== 4'b1000) begin
      errors++;
      $display("FAIL two_words_done: done,cpu_rst,ld,W=%b, required 1000",
               {dif.done, dif.cpu_reset, dif.ld_active, dif.W});
    end
    dif.byte_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (w_count - wc0 !== 2) begin
      errors++;
      $display("FAIL two_words_count: writes=%0d, required 2", w_count - wc0);
    end
  endtask

  task automatic test_zero_and_after_done();
    int wc0;
    int bad;
    do_reset();
    wc0 = w_count;
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    checks++;
    if ({dif.done, dif.cpu_reset, dif.ld_active, dif.err} !== 4'b1000) begin
      errors++;
      $display("FAIL zero_done: done,cpu_rst,ld,err=%b, required 1000",
               {dif.done, dif.cpu_reset, dif.ld_active, dif.err});
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      dif.byte_valid = 1'b1;
      dif.byte_data  = 8'(i * 37 + 1);
      #1;
      if (dif.byte_ready !== 1'b0 || dif.done !== 1'b1) bad++;
    end
    dif.byte_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL after_done_ignore: bad_cycles=%0d, required 0", bad);
    end
    checks++;
    if (w_count - wc0 !== 0) begin
      errors++;
      $display("FAIL zero_no_write: writes=%0d, required 0", w_count - wc0);
    end
  endtask

  task automatic test_err();
    int wc0;
    int bad;
    do_reset();
    wc0 = w_count;
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    checks++;
    if ({dif.err, dif.cpu_reset, dif.byte_ready, dif.ld_active, dif.done} !== 5'b11010) begin
      errors++;
      $display("FAIL err_state: err,cpu_rst,rdy,ld,done=%b, required 11010",
               {dif.err, dif.cpu_reset, dif.byte_ready, dif.ld_active, dif.done});
    end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      dif.byte_valid = 1'b1;
      dif.byte_data  = 8'(i + 8'h40);
      #1;
      if (dif.err !== 1'b1 || dif.byte_ready !== 1'b0 || dif.cpu_reset !== 1'b1) bad++;
    end
    dif.byte_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bad !== 0 || w_count - wc0 !== 0) begin
      errors++;
      $display("FAIL err_hold: bad_cycles=%0d writes=%0d, required 0 0", bad, w_count - wc0);
    end
  endtask

  task automatic test_mid_reset();
    int wc0;
    do_reset();
    wc0 = w_count;
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_word(32'hA5A5_1234, 0, 1'b0);
    send_byte(8'h77, 0);
    send_byte(8'h66, 0);
    dif.byte_valid = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({dif.byte_ready, dif.W, dif.R, dif.ld_active, dif.cpu_reset, dif.done, dif.err} !== 7'b0001100 ||
        dif.Addr !== 32'd0 || dif.W_data !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: ctrl=%b Addr=%h W_data=%h, required 0001100 0 0",
               {dif.byte_ready, dif.W, dif.R, dif.ld_active, dif.cpu_reset, dif.done, dif.err},
               dif.Addr, dif.W_data);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (w_count - wc0 !== 1) begin
      errors++;
      $display("FAIL mid_reset_count: writes=%0d, required 1", w_count - wc0);
    end
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_word(32'hDDCC_BBAA, 0, 1'b0);
    dif.byte_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (dif.done !== 1'b1 || w_count - wc0 !== 2) begin
      errors++;
      $display("FAIL restart_load: done=%b writes=%0d, required 1 2", dif.done, w_count - wc0);
    end
  endtask

  task automatic test_back_to_back_max();
    int wc0;
    do_reset();
    wc0 = w_count;
    send_byte(8'h00, 1);
    send_byte(8'h04, 2);
    for (int i = 0; i < 1024; i++) begin
      send_word($urandom, i, 1'b1);
    end
    dif.byte_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (w_count - wc0 !== 1024) begin
      errors++;
      $display("FAIL max_count: writes=%0d, required 1024", w_count - wc0);
    end
    checks++;
    if (last_addr !== 32'd8188) begin
      errors++;
      $display("FAIL max_last_addr: Addr=%0d, required 8188", last_addr);
    end
    checks++;
    if (dif.done !== 1'b1 || dif.err !== 1'b0) begin
      errors++;
      $display("FAIL max_done: done=%b err=%b, required 1 0", dif.done, dif.err);
    end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_zero_and_after_done();
    test_err();
    test_mid_reset();
    test_back_to_back_max();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: pending=%0d, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'd4096: byte address of the first loaded word (instruction region, word 1024).
REQ-002 Parameter MAX_WORDS, default 1024: largest legal word count.
REQ-003 CLK  input  1  system clock; all state changes on posedge CLK.
REQ-004 RESET  input  1  reset, asynchronous, active-high.
REQ-005 byte_valid  input  1  upstream byte stream: byte_data holds a valid byte.
REQ-006 byte_data  input  8  stream byte.
REQ-007 byte_ready  output  1  loader accepts the byte this cycle; a transfer occurs when byte_valid and byte_ready are both 1 at posedge CLK.
REQ-008 Addr  output  32  memory byte address.
REQ-009 W_data  output  32  memory write data.
REQ-010 W  output  1  memory write strobe.
REQ-011 R  output  1  memory read strobe; constant 0.
REQ-012 ld_active  output  1  loader owns the memory port; selects the loader into the memory-port mux.
REQ-013 cpu_reset  output  1  holds the CPU PC and control unit in reset until the load completes.
REQ-014 done  output  1  load completed successfully.
REQ-015 err  output  1  header rejected.

Function
REQ-016 Stream format: 2-byte word count N, little-endian, then N words of 4 bytes each, little-endian (first byte goes to W_data[7:0]).
REQ-017 States: HDR0, HDR1, WBYTE, WRITE, DONE, ERR; the state after reset is HDR0.
REQ-018 HDR0: byte_ready=1; an accepted byte goes to N[7:0] and the state moves to HDR1.
REQ-019 HDR1: byte_ready=1; an accepted byte goes to N[15:8].
REQ-019a HDR1 next state: DONE if N=0; ERR if N>MAX_WORDS; otherwise WBYTE with word index 0 and byte index 0.
REQ-020 WBYTE: byte_ready=1; each accepted byte goes into the assembly register at lane byte_idx; byte_idx increments.
REQ-020a WBYTE: when the 4th byte (byte_idx=3) is accepted, byte_idx wraps to 0 and the state moves to WRITE.
REQ-021 WBYTE: cycles without byte_valid cause no state or register change; there is no timeout.
REQ-022 WRITE: lasts exactly one cycle, with W=1, Addr=BASE_ADDR+4*word_idx and W_data=the assembled word; byte_ready=0, so a byte_valid asserted here is not consumed.
REQ-023 WRITE exit: word_idx increments; the next state is DONE if word_idx+1=N, else WBYTE.
REQ-024 Addr and W_data are registered outputs, stable for the whole WRITE cycle; W is 0 in every other state.
REQ-025 ld_active=1 in HDR0, HDR1, WBYTE, WRITE and ERR; ld_active=0 in DONE.
REQ-026 DONE: done=1, cpu_reset=0, byte_ready=0; the state holds until RESET; further stream bytes are ignored.
REQ-027 ERR: err=1, cpu_reset=1, byte_ready=0, W=0; the state holds until RESET.
REQ-028 Latency: the 4th byte of a word is accepted at edge k; W=1 for the cycle after edge k.
REQ-028a If that word is the last, done=1 and cpu_reset=0 after edge k+1.
REQ-029 Width: word_idx is 11 bits and N is 16 bits; the address arithmetic is 32-bit unsigned.

Reset
REQ-030 RESET=1 forces immediately, without waiting for CLK: state HDR0, N=0, word_idx=0, byte_idx=0, Addr=0, W_data=0, W=0, R=0, byte_ready=0 while RESET is high, ld_active=1, cpu_reset=1, done=0, err=0.
REQ-031 After RESET deasserts, byte_ready=1 in HDR0.
REQ-032 RESET mid-load discards any partial word and restarts at HDR0; words already written to memory are not altered.

Verification
REQ-033 Stream 02 00 | 20 08 01 00 | 03 11 00 00 -> W pulses with Addr=4096, W_data=0x00010820, then Addr=4100, W_data=0x00001103; then done=1 and cpu_reset=0 one cycle after the second W.
REQ-034 Stream 00 00 -> no W pulse; done=1 after the second header byte.
REQ-035 Stream 01 04 (N=1025) -> err=1, cpu_reset stays 1, byte_ready=0, no W pulse.
REQ-036 N=1024 with gapped byte_valid -> exactly 1024 W pulses, last Addr=8188; byte_valid held high during WRITE is not consumed and no byte is lost or duplicated.
REQ-037 RESET pulsed after 2 bytes of word 1 -> all outputs return to reset values; a new stream 01 00 AA BB CC DD writes 0xDDCCBBAA at 4096.
REQ-038 Any bytes presented after DONE -> byte_ready=0, no W pulse, done stays 1.
